cordic_post: RTL and testbench

//  Post-processing stage after the CORDIC iteration pipeline; the counterpart of cordic_pre.

---
 rtl/cordic_post_if.sv | 30 +++
 rtl/cordic_post.sv | 169 ++++++++++++++++
 tb/tb_cordic_post.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_post_if.sv
// Stream bundle between the CORDIC core and cordic_post.
// master drives pi_* (sample in) and sees po_*; slave is the reverse.
//   pi_dv/pi_x/pi_y/pi_z/pi_info : input sample, valid-qualified
//   po_dv/po_x/po_y/po_z/po_ovf  : output sample, valid-qualified
interface cordic_post_if #(
    parameter int DW = 14,
    parameter int AW = 20
);
    logic                 pi_dv;
    logic signed [DW-1:0] pi_x;
    logic signed [DW-1:0] pi_y;
    logic [AW-1:0]        pi_z;
    logic [AW+1:0]        pi_info;

    logic                 po_dv;
    logic signed [DW-1:0] po_x;
    logic signed [DW-1:0] po_y;
    logic [AW-1:0]        po_z;
    logic                 po_ovf;

    modport master (
        output pi_dv, pi_x, pi_y, pi_z, pi_info,
        input  po_dv, po_x, po_y, po_z, po_ovf
    );

    modport slave (
        input  pi_dv, pi_x, pi_y, pi_z, pi_info,
        output po_dv, po_x, po_y, po_z, po_ovf
    );
endinterface

// File: rtl/cordic_post.sv
// CORDIC post stage: maps first-quadrant results back to the full circle.
// NCO: signs cos/sin from the quadrant bits. ANGLE: rebuilds 0..2pi phase
// and emits the magnitude. Other CORDIC_MODE values tie all outputs to 0.
// Ports: clk, rst_n (async, active low), bus (cordic_post_if.slave).
// `define CORDIC_POST_GAIN_COMP_EN adds the 1/K gain stage (latency 3, else 2).
module cordic_post #(
    parameter string CORDIC_MODE = "NCO",
    parameter int    DW          = 14,
    parameter int    AW          = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    cordic_post_if.slave  bus
);
    localparam bit IS_NCO  = (CORDIC_MODE == "NCO");
    localparam bit IS_ANG  = (CORDIC_MODE == "ANGLE");
    localparam bit MODE_OK = IS_NCO || IS_ANG;

    localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [AW-1:0] ONE_PI = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] TWO_PI = {AW{1'b1}};

    // {ovf, value}: the most negative code has no positive twin
    function automatic logic [DW:0] neg_sat(input logic signed [DW-1:0] a);
        if (a == S_MIN) return {1'b1, S_MAX};
        return {1'b0, -a};
    endfunction

    // ---------------- S1: quadrant mapping
    logic [1:0]    q;
    logic [AW-1:0] th;
    logic [DW:0]   nx_w;
    logic [DW:0]   ny_w;
    logic unused_z;

    assign q    = bus.pi_info[AW+1:AW];
    assign th   = bus.pi_info[AW-1:0];
    assign nx_w = q[1] ? neg_sat(bus.pi_x) : {1'b0, bus.pi_x};
    assign ny_w = q[0] ? neg_sat(bus.pi_y) : {1'b0, bus.pi_y};
    assign unused_z = ^bus.pi_z;

    logic signed [DW-1:0] n_x;
    logic signed [DW-1:0] n_y;
    logic [AW-1:0]        n_z;
    logic                 n_ovf;

    always_comb begin
        n_x   = '0;
        n_y   = '0;
        n_z   = '0;
        n_ovf = 1'b0;
        unique case (1'b1)
            IS_NCO: begin
                n_x   = nx_w[DW-1:0];
                n_y   = ny_w[DW-1:0];
                n_ovf = nx_w[DW] | ny_w[DW];
            end
            IS_ANG: begin
                n_x = bus.pi_x[DW-1] ? '0 : bus.pi_x;
                unique case (q)
                    2'b00:   n_z = th;
                    2'b10:   n_z = ONE_PI - th;
                    2'b11:   n_z = ONE_PI + th;
                    default: n_z = TWO_PI - th;
                endcase
            end
            default: ;
        endcase
    end

    logic                 v1;
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] y1;
    logic [AW-1:0]        z1;
    logic                 ovf1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            x1   <= '0;
            y1   <= '0;
            z1   <= '0;
            ovf1 <= 1'b0;
        end else begin
            v1 <= bus.pi_dv && MODE_OK;
            if (bus.pi_dv) begin
                x1   <= n_x;
                y1   <= n_y;
                z1   <= n_z;
                ovf1 <= n_ovf;
            end
        end
    end

    // ---------------- S2: optional 1/K gain compensation
    logic                 v2;
    logic signed [DW-1:0] x2;
    logic signed [DW-1:0] y2;
    logic [AW-1:0]        z2;
    logic                 ovf2;

`ifdef CORDIC_POST_GAIN_COMP_EN
    localparam logic signed [DW+17:0] KINV  = (DW+18)'(39797);
    localparam logic signed [DW+17:0] RND   = (DW+18)'(32768);
    localparam logic signed [DW+17:0] E_MAX = (DW+18)'(S_MAX);
    localparam logic signed [DW+17:0] E_MIN = -E_MAX - 1;

    // round half up, then clamp to DW bits; {ovf, value}
    function automatic logic [DW:0] gain(input logic signed [DW-1:0] a);
        logic signed [DW+17:0] e;
        logic signed [DW+17:0] r;
        e = {{18{a[DW-1]}}, a};
        r = (e * KINV + RND) >>> 16;
        if (r > E_MAX) return {1'b1, S_MAX};
        if (r < E_MIN) return {1'b1, S_MIN};
        return {1'b0, r[DW-1:0]};
    endfunction

    logic [DW:0] gx_w;
    logic [DW:0] gy_w;

    assign gx_w = gain(x1);
    assign gy_w = gain(y1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            x2   <= '0;
            y2   <= '0;
            z2   <= '0;
            ovf2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                x2   <= gx_w[DW-1:0];
                y2   <= gy_w[DW-1:0];
                z2   <= z1;
                ovf2 <= ovf1 | gx_w[DW] | gy_w[DW];
            end
        end
    end
`else
    assign v2   = v1;
    assign x2   = x1;
    assign y2   = y1;
    assign z2   = z1;
    assign ovf2 = ovf1;
`endif

    // ---------------- S3: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.po_dv  <= 1'b0;
            bus.po_x   <= '0;
            bus.po_y   <= '0;
            bus.po_z   <= '0;
            bus.po_ovf <= 1'b0;
        end else begin
            bus.po_dv <= v2;
            if (v2) begin
                bus.po_x   <= x2;
                bus.po_y   <= y2;
                bus.po_z   <= z2;
                bus.po_ovf <= ovf2;
            end
        end
    end
endmodule

// File: tb/tb_cordic_post.sv
// Randomized bench for cordic_post: NCO and ANGLE instances share a stream
// and are scored against an arithmetic model of the quadrant/gain rules.
module tb_cordic_post;
    localparam int DW = 14;
    localparam int AW = 20;
`ifdef CORDIC_POST_GAIN_COMP_EN
    localparam int L  = 3;
    localparam bit GC = 1'b1;
`else
    localparam int L  = 2;
    localparam bit GC = 1'b0;
`endif
    localparam longint VMAX   = (64'sd1 <<< (DW-1)) - 1;
    localparam longint VMIN   = -(64'sd1 <<< (DW-1));
    localparam longint ONE_PI = (64'sd1 <<< (AW-1)) - 1;
    localparam longint TWO_PI = (64'sd1 <<< AW) - 1;
    localparam int     HN     = 4096;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_post_if #(.DW(DW), .AW(AW)) n_if ();
    cordic_post_if #(.DW(DW), .AW(AW)) a_if ();

    cordic_post #(.CORDIC_MODE("NCO"), .DW(DW), .AW(AW)) u_nco (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (n_if)
    );

    cordic_post #(.CORDIC_MODE("ANGLE"), .DW(DW), .AW(AW)) u_ang (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // expected outputs per input cycle
    bit     h_dv  [HN];
    longint h_nx  [HN];
    longint h_ny  [HN];
    bit     h_nov [HN];
    longint h_ax  [HN];
    longint h_az  [HN];
    int     cyc = 0;

    // currently expected (held) output values
    longint e_nx = 0, e_ny = 0, e_ax = 0, e_az = 0;
    bit     e_nov = 0;

    function automatic longint clamp(input longint v, inout bit o);
        if (v > VMAX) begin o = 1'b1; return VMAX; end
        if (v < VMIN) begin o = 1'b1; return VMIN; end
        return v;
    endfunction

    function automatic longint floordiv(input longint n, input longint d);
        longint r;
        r = n / d;
        if ((n % d != 0) && (n < 0)) r = r - 1;
        return r;
    endfunction

    function automatic longint scale(input longint v, inout bit o);
        if (!GC) return v;
        return clamp(floordiv(v * 39797 + 32768, 65536), o);
    endfunction

    task automatic record(input bit dv, input int x, input int y,
                          input int q, input int th);
        bit     o  = 1'b0;
        bit     o2 = 1'b0;
        longint nx, ny, m, p;
        nx = q[1] ? -longint'(x) : longint'(x);
        ny = q[0] ? -longint'(y) : longint'(y);
        nx = scale(clamp(nx, o), o);
        ny = scale(clamp(ny, o), o);
        m  = (x < 0) ? 0 : x;
        m  = scale(m, o2);
        case (q)
            0:       p = th;
            2:       p = ONE_PI - th;
            3:       p = ONE_PI + th;
            default: p = TWO_PI - th;
        endcase
        p = p & TWO_PI;
        h_dv[cyc]  = dv;
        h_nx[cyc]  = nx;
        h_ny[cyc]  = ny;
        h_nov[cyc] = o;
        h_ax[cyc]  = m;
        h_az[cyc]  = p;
        cyc++;
    endtask

    task automatic check_out();
        int idx;
        bit dv;
        idx = cyc - L;
        dv  = (idx >= 0) ? h_dv[idx] : 1'b0;
        if (dv) begin
            e_nx  = h_nx[idx];
            e_ny  = h_ny[idx];
            e_nov = h_nov[idx];
            e_ax  = h_ax[idx];
            e_az  = h_az[idx];
        end
        chk("nco_dv",  n_if.po_dv,  dv);
        chk("nco_x",   n_if.po_x,   e_nx);
        chk("nco_y",   n_if.po_y,   e_ny);
        chk("nco_z",   n_if.po_z,   0);
        chk("nco_ovf", n_if.po_ovf, e_nov);
        chk("ang_dv",  a_if.po_dv,  dv);
        chk("ang_x",   a_if.po_x,   e_ax);
        chk("ang_y",   a_if.po_y,   0);
        chk("ang_z",   a_if.po_z,   e_az);
        chk("ang_ovf", a_if.po_ovf, 0);
    endtask

    task automatic drive(input bit dv, input int x, input int y,
                         input int q, input int th);
        logic [AW+1:0] info;
        logic [AW-1:0] zr;
        info = {2'(q), AW'(th)};
        zr   = AW'($urandom);
        n_if.pi_dv   = dv;
        n_if.pi_x    = DW'(x);
        n_if.pi_y    = DW'(y);
        n_if.pi_z    = zr;
        n_if.pi_info = info;
        a_if.pi_dv   = dv;
        a_if.pi_x    = DW'(x);
        a_if.pi_y    = DW'(y);
        a_if.pi_z    = zr;
        a_if.pi_info = info;
    endtask

    task automatic step(input bit dv, input int x, input int y,
                        input int q, input int th);
        @(negedge clk);
        check_out();
        drive(dv, x, y, q, th);
        record(dv, x, y, q, th);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_nco_dv"},  n_if.po_dv,  0);
        chk({tag, "_nco_x"},   n_if.po_x,   0);
        chk({tag, "_nco_y"},   n_if.po_y,   0);
        chk({tag, "_nco_ovf"}, n_if.po_ovf, 0);
        chk({tag, "_ang_dv"},  a_if.po_dv,  0);
        chk({tag, "_ang_x"},   a_if.po_x,   0);
        chk({tag, "_ang_z"},   a_if.po_z,   0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        for (int i = 0; i < cyc; i++) h_dv[i] = 1'b0;
        e_nx = 0; e_ny = 0; e_nov = 0; e_ax = 0; e_az = 0;
        n_if.pi_dv = 1'b0;
        a_if.pi_dv = 1'b0;
        record(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        check_out();
        rst_n = 1'b1;
        record(1'b0, 0, 0, 0, 0);
    endtask

    function automatic int rnd_s();
        if ($urandom_range(0, 9) == 0) return -8192;
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;

        // directed corners
        step(1'b1, 1000, 500, 2, 0);
        step(1'b0, 0, 0, 0, 0);
        step(1'b1, -8192, 100, 3, 0);
        step(1'b1, 8000, 0, 0, 0);
        step(1'b1, 100, -8192, 1, 0);
        step(1'b1, 3000, -20, 0, 100000);
        step(1'b1, 3000, -20, 2, 100000);
        step(1'b1, -5, -20, 3, 100000);
        step(1'b1, 8191, -20, 1, 100000);
        step(1'b1, 0, 0, 0, 0);
        step(1'b1, 0, 0, 1, 0);
        repeat (3) step(1'b0, 7, 7, 3, 5);

        // back-to-back ramp
        for (int i = 0; i < 100; i++)
            step(1'b1, i * 37 - 1800, 1500 - i * 29, i % 4, i * 9973);

        // random traffic with a reset in the middle
        for (int i = 0; i < 300; i++) begin
            if (i == 150) mid_reset();
            step($urandom_range(0, 3) != 0, rnd_s(), rnd_s(),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, (1 << AW) - 1)));
        end

        repeat (L + 3) step(1'b0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
